bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TURN_CYCLES, default 2: idle sysclk cycles between any two bus owners.
REQ-002 Parameter DMA_MAX_CYCLES, default 512: DMA ownership watchdog limit, in sysclk cycles.
REQ-003 sysclk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  Maria DMA enable.
REQ-006 core_latch_data  in  1  one-cycle strobe marking a CPU cycle boundary.
REQ-007 halt_b  in  1  active-low DMA halt request from the timing controller.
REQ-008 cpu_addr  in  16  CPU address.
REQ-009 cpu_we  in  1  CPU write enable.
REQ-010 cpu_dout  in  8  CPU write data.
REQ-011 dma_req  in  1  DMA read request, one per cycle.
REQ-012 dma_addr  in  16  DMA address.
REQ-013 dma_ack  out  1  DMA request accepted this cycle.
REQ-014 dbg_req  in  1  debug/loader access request; held until acknowledged.
REQ-015 dbg_addr  in  16  debug address.
REQ-016 dbg_we  in  1  debug write enable.
REQ-017 dbg_din  in  8  debug write data.
REQ-018 dbg_ack  out  1  one-cycle debug completion pulse.
REQ-019 mem_addr  out  16  shared bus address.
REQ-020 mem_we  out  1  shared bus write strobe.
REQ-021 mem_din  out  8  shared bus write data.
REQ-022 owner  out  2  current owner: 0 = CPU, 1 = DMA, 2 = debug, 3 = none (turnaround).
REQ-023 cpu_wait  out  1  stretches the current CPU cycle.
REQ-024 dma_timeout  out  1  sticky watchdog flag.

Function
REQ-025 States SHALL be CPU_OWN, TURN_DMA, DMA_OWN, TURN_CPU and DBG_OWN.
REQ-026 CPU_OWN -> TURN_DMA SHALL occur when enable=1, halt_b=0 and core_latch_data=1 are true in the same cycle; halt_b low without the strobe SHALL keep the state in CPU_OWN.
REQ-027 TURN_DMA and TURN_CPU SHALL each last exactly TURN_CYCLES cycles (down-counter), with owner=3, mem_we=0 and cpu_wait=1, then move to DMA_OWN or CPU_OWN respectively.
REQ-028 In DMA_OWN: dma_ack = dma_req, combinational, same cycle; mem_addr=dma_addr; mem_we=0; cpu_wait=1.
REQ-029 DMA_OWN -> TURN_CPU SHALL occur on halt_b=1, on enable=0, or when the ownership counter reaches DMA_MAX_CYCLES; the watchdog case SHALL set dma_timeout.
REQ-030 After a watchdog release, re-entry to DMA SHALL require halt_b to have been observed high at least once.
REQ-031 enable=0 in TURN_DMA SHALL divert the state to TURN_CPU with its counter reloaded; dma_ack=0 outside DMA_OWN.
REQ-032 CPU_OWN -> DBG_OWN SHALL occur on dbg_req=1 with core_latch_data=1 and no DMA transition in that cycle; a simultaneous halt request SHALL win.
REQ-033 DBG_OWN SHALL last exactly one cycle: mem_addr=dbg_addr, mem_we=dbg_we, mem_din=dbg_din, cpu_wait=1, dbg_ack=1, then return to CPU_OWN with no turnaround.
REQ-034 Back-to-back debug grants SHALL be separated by at least one CPU_OWN cycle containing a core_latch_data strobe.
REQ-035 In CPU_OWN: mem_addr=cpu_addr, mem_we=cpu_we, mem_din=cpu_dout, cpu_wait=0.
REQ-036 In all non-debug, non-CPU states mem_din=0.
REQ-037 dma_timeout SHALL clear only on reset.
REQ-038 The ownership counter SHALL be 10 bits, saturating at DMA_MAX_CYCLES, and cleared on entry to DMA_OWN.

Reset
REQ-039 On reset: state=CPU_OWN, owner=0, dma_ack=0, dbg_ack=0, cpu_wait=0, dma_timeout=0, all counters=0, mem_we=0.
REQ-040 Reset asserted mid-DMA or mid-turnaround SHALL return ownership to the CPU immediately, with no turnaround.

Configuration
REQ-041 With BUS_ARB_DBG_PORT_EN defined, the debug path SHALL behave per REQ-032 to REQ-034.
REQ-042 Without BUS_ARB_DBG_PORT_EN, DBG_OWN SHALL be unreachable, dbg_ack SHALL be constant 0, dbg inputs SHALL be ignored, and the ports SHALL remain present.

Verification
REQ-043 halt_b low, strobe 3 cycles later -> owner=3 for 2 cycles, then owner=1 and dma_ack follows dma_req; owner stays 0 before the strobe.
REQ-044 halt_b high during DMA_OWN -> owner=3 for 2 cycles, then 0, and cpu_wait falls with owner=0.
REQ-045 halt_b held low for 600 cycles, DMA_MAX_CYCLES=512 -> release after 512 DMA cycles, dma_timeout=1, no re-grant until halt_b toggles high.
REQ-046 dbg_req with dbg_we=1, dbg_addr=16'h2000, dbg_din=8'hA5, simultaneous with halt request -> DMA wins; the debug write (addr 16'h2000, data 8'hA5) completes on the first strobe after return to CPU_OWN, with a single dbg_ack pulse.
REQ-047 enable dropped during TURN_DMA -> goes to TURN_CPU; dma_ack never asserts.
REQ-048 Reset pulsed in DMA_OWN -> owner=0, cpu_wait=0 in the next cycle; build without the macro -> dbg_ack stays 0 under dbg_req.

Source files
------------

// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Shared-bus arbiter between the CPU, the Maria DMA engine and an
//             optional debug/loader port, with turnaround gaps and a DMA
//             ownership watchdog. The debug path is built only when the macro
//             BUS_ARB_DBG_PORT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int TURN_CYCLES    = 2,
  parameter int DMA_MAX_CYCLES = 512
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        core_latch_data,
  input  logic        halt_b,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_dout,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic        dma_ack,
  input  logic        dbg_req,
  input  logic [15:0] dbg_addr,
  input  logic        dbg_we,
  input  logic [7:0]  dbg_din,
  output logic        dbg_ack,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  output logic [1:0]  owner,
  output logic        cpu_wait,
  output logic        dma_timeout
);

  typedef enum logic [2:0] {
    CPU_OWN  = 3'd0,
    TURN_DMA = 3'd1,
    DMA_OWN  = 3'd2,
    TURN_CPU = 3'd3,
    DBG_OWN  = 3'd4
  } state_t;

  localparam int              c_TW        = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TURN_LOAD = c_TW'(TURN_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TURN_ONE  = c_TW'(1);
  localparam logic [9:0]      c_DMA_MAX   = 10'(DMA_MAX_CYCLES);
  localparam logic [1:0]      c_OWN_CPU   = 2'd0;
  localparam logic [1:0]      c_OWN_DMA   = 2'd1;
  localparam logic [1:0]      c_OWN_DBG   = 2'd2;
  localparam logic [1:0]      c_OWN_NONE  = 2'd3;

  state_t          r_state;
  logic [c_TW-1:0] r_turn_cnt;
  logic [9:0]      r_own_cnt;
  logic            r_wd_lock;
  logic            r_dbg_block;

  logic            w_dma_start;
  logic            w_dbg_grant;
  logic [9:0]      w_own_inc;
  logic            w_wd_hit;

  // After a watchdog release the DMA stays locked out until halt_b is seen high.
  assign w_dma_start = enable & ~halt_b & core_latch_data & ~r_wd_lock;
  assign w_own_inc   = (r_own_cnt == c_DMA_MAX) ? r_own_cnt : r_own_cnt + 10'd1;
  assign w_wd_hit    = (w_own_inc == c_DMA_MAX);

`ifdef BUS_ARB_DBG_PORT_EN
  assign w_dbg_grant = dbg_req & core_latch_data & ~r_dbg_block;
`else
  logic w_unused_dbg;
  assign w_dbg_grant  = 1'b0;
  assign w_unused_dbg = dbg_req ^ r_dbg_block;
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state     <= CPU_OWN;
      r_turn_cnt  <= '0;
      r_own_cnt   <= '0;
      r_wd_lock   <= 1'b0;
      r_dbg_block <= 1'b0;
      owner       <= c_OWN_CPU;
      cpu_wait    <= 1'b0;
      dbg_ack     <= 1'b0;
      dma_timeout <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      if (halt_b) r_wd_lock <= 1'b0;
      case (r_state)
        CPU_OWN: begin
          if (w_dma_start) begin
            r_state    <= TURN_DMA;
            r_turn_cnt <= c_TURN_LOAD;
            owner      <= c_OWN_NONE;
            cpu_wait   <= 1'b1;
          end else if (w_dbg_grant) begin
            r_state     <= DBG_OWN;
            r_dbg_block <= 1'b1;
            owner       <= c_OWN_DBG;
            cpu_wait    <= 1'b1;
            dbg_ack     <= 1'b1;
          end else if (core_latch_data) begin
            // a strobe spent in CPU_OWN re-arms the next debug grant
            r_dbg_block <= 1'b0;
          end
        end
        TURN_DMA: begin
          if (!enable) begin
            r_state    <= TURN_CPU;
            r_turn_cnt <= c_TURN_LOAD;
          end else if (r_turn_cnt == '0) begin
            r_state   <= DMA_OWN;
            r_own_cnt <= '0;
            owner     <= c_OWN_DMA;
          end else begin
            r_turn_cnt <= r_turn_cnt - c_TURN_ONE;
          end
        end
        DMA_OWN: begin
          r_own_cnt <= w_own_inc;
          if (halt_b || !enable) begin
            r_state    <= TURN_CPU;
            r_turn_cnt <= c_TURN_LOAD;
            owner      <= c_OWN_NONE;
          end else if (w_wd_hit) begin
            r_state     <= TURN_CPU;
            r_turn_cnt  <= c_TURN_LOAD;
            owner       <= c_OWN_NONE;
            dma_timeout <= 1'b1;
            r_wd_lock   <= 1'b1;
          end
        end
        TURN_CPU: begin
          if (r_turn_cnt == '0) begin
            r_state  <= CPU_OWN;
            owner    <= c_OWN_CPU;
            cpu_wait <= 1'b0;
          end else begin
            r_turn_cnt <= r_turn_cnt - c_TURN_ONE;
          end
        end
        DBG_OWN: begin
          r_state  <= CPU_OWN;
          owner    <= c_OWN_CPU;
          cpu_wait <= 1'b0;
        end
        default: begin
          r_state  <= CPU_OWN;
          owner    <= c_OWN_CPU;
          cpu_wait <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_din  = '0;
    dma_ack  = 1'b0;
    case (r_state)
      CPU_OWN: begin
        mem_addr = cpu_addr;
        mem_we   = cpu_we & ~reset;
        mem_din  = cpu_dout;
      end
      DMA_OWN: begin
        mem_addr = dma_addr;
        dma_ack  = dma_req;
      end
      DBG_OWN: begin
        mem_addr = dbg_addr;
        mem_we   = dbg_we;
        mem_din  = dbg_din;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed self-checking bench for bus_arbiter (default params).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  logic        sysclk, reset, enable, core_latch_data, halt_b;
  logic [15:0] cpu_addr, dma_addr, dbg_addr, mem_addr;
  logic        cpu_we, dma_req, dma_ack, dbg_req, dbg_we, dbg_ack, mem_we;
  logic [7:0]  cpu_dout, dbg_din, mem_din;
  logic [1:0]  owner;
  logic        cpu_wait, dma_timeout;

`ifdef BUS_ARB_DBG_PORT_EN
  localparam logic [1:0] c_DBG_OWNER = 2'd2;
`else
  localparam logic [1:0] c_DBG_OWNER = 2'd0;
`endif

  bus_arbiter dut (
    .sysclk(sysclk), .reset(reset), .enable(enable),
    .core_latch_data(core_latch_data), .halt_b(halt_b),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_din(dbg_din),
    .dbg_ack(dbg_ack), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .owner(owner), .cpu_wait(cpu_wait), .dma_timeout(dma_timeout)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    string      tag;
    logic [1:0] own;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  logic exp_tmo;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, got, want);
    end
  endtask

  // Expected bus view follows from the predicted owner and the live inputs.
  task automatic check_front();
    exp_t        e;
    logic [31:0] got, want, mask;
    logic        w_cw, w_ack, w_dack, w_we;
    logic [15:0] w_addr, m_addr;
    logic [7:0]  w_din;
    e      = sb.pop_front();
    w_cw   = 1'b1; w_ack = 1'b0; w_dack = 1'b0; w_we = 1'b0;
    w_addr = 16'h0; w_din = 8'h0; m_addr = 16'hFFFF;
    case (e.own)
      2'd0: begin w_cw = 1'b0; w_addr = cpu_addr; w_we = cpu_we; w_din = cpu_dout; end
      2'd1: begin w_ack = dma_req; w_addr = dma_addr; end
      2'd2: begin w_dack = 1'b1; w_addr = dbg_addr; w_we = dbg_we; w_din = dbg_din; end
      default: m_addr = 16'h0;
    endcase
    mask = {1'b0, 2'b11, 4'hF, m_addr, 1'b1, 8'hFF};
    want = {1'b0, e.own, w_cw, w_ack, w_dack, e.tmo, w_addr, w_we, w_din};
    got  = {1'b0, owner, cpu_wait, dma_ack, dbg_ack, dma_timeout, mem_addr, mem_we, mem_din};
    check(e.tag, got & mask, want & mask);
  endtask

  task automatic cyc(input string tag, input logic [1:0] own);
    exp_t e;
    e.tag = tag; e.own = own; e.tmo = exp_tmo;
    sb.push_back(e);
    @(posedge sysclk); #1;
    check_front();
  endtask

  task automatic comb(input string tag, input logic [1:0] own);
    exp_t e;
    e.tag = tag; e.own = own; e.tmo = exp_tmo;
    sb.push_back(e);
    #1;
    check_front();
  endtask

  initial begin
    int dma_cycles;
    bit done;
    reset = 1'b1; enable = 1'b1; core_latch_data = 1'b0; halt_b = 1'b1;
    cpu_addr = 16'h1234; cpu_we = 1'b1; cpu_dout = 8'h5A;
    dma_req = 1'b0; dma_addr = 16'h8000;
    dbg_req = 1'b0; dbg_addr = 16'h0000; dbg_we = 1'b0; dbg_din = 8'h00;
    exp_tmo = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    check("reset_state", {26'd0, owner, cpu_wait, dma_ack, dbg_ack, dma_timeout, mem_we}, 32'd0);
    reset = 1'b0;
    cyc("cpu_idle", 2'd0);

    // halt request without a strobe keeps the CPU on the bus
    halt_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 16'h1000 + 16'(i); cpu_dout = 8'(8'h10 + i); cpu_we = i[0];
      cyc("halt_no_strobe", 2'd0);
    end
    core_latch_data = 1'b1; dma_req = 1'b1;
    cyc("turn_dma_1", 2'd3);
    core_latch_data = 1'b0;
    cyc("turn_dma_2", 2'd3);
    cyc("dma_own_ack", 2'd1);
    dma_req = 1'b0; dma_addr = 16'h8042;
    comb("dma_ack_follow", 2'd1);

    halt_b = 1'b1; dma_req = 1'b1;
    cyc("turn_cpu_1", 2'd3);
    cyc("turn_cpu_2", 2'd3);
    cyc("cpu_back", 2'd0);

    // enable dropped in the second turnaround cycle
    halt_b = 1'b0; core_latch_data = 1'b1;
    cyc("abort_turn_1", 2'd3);
    core_latch_data = 1'b0;
    cyc("abort_turn_2", 2'd3);
    enable = 1'b0;
    cyc("abort_divert", 2'd3);
    cyc("abort_reload", 2'd3);
    cyc("abort_cpu", 2'd0);
    enable = 1'b1; halt_b = 1'b1; dma_req = 1'b0;
    cyc("abort_idle", 2'd0);

    // watchdog: halt_b held low well past the ownership limit
    halt_b = 1'b0; core_latch_data = 1'b1;
    cyc("wd_turn_1", 2'd3);
    core_latch_data = 1'b0;
    cyc("wd_turn_2", 2'd3);
    dma_cycles = 0; done = 1'b0;
    for (int i = 0; i < 700 && !done; i++) begin
      dma_req = 1'($urandom_range(0, 1));
      @(posedge sysclk); #1;
      if (owner == 2'd1) dma_cycles++;
      else if (dma_cycles > 0) done = 1'b1;
    end
    check("wd_dma_len", 32'(dma_cycles), 32'd512);
    check("wd_flag", {29'd0, owner, dma_timeout}, {29'd0, 2'd3, 1'b1});
    exp_tmo = 1'b1;
    cyc("wd_turn_cpu", 2'd3);
    cyc("wd_cpu", 2'd0);
    core_latch_data = 1'b1;
    cyc("wd_no_regrant_1", 2'd0);
    cyc("wd_no_regrant_2", 2'd0);
    halt_b = 1'b1; core_latch_data = 1'b0;
    cyc("wd_halt_high", 2'd0);
    halt_b = 1'b0; core_latch_data = 1'b1;
    cyc("wd_regrant_1", 2'd3);
    core_latch_data = 1'b0;
    cyc("wd_regrant_2", 2'd3);
    dma_req = 1'b1;
    cyc("wd_regrant_dma", 2'd1);

    // asynchronous reset while the DMA owns the bus
    reset = 1'b1;
    #1;
    check("reset_in_dma", {29'd0, owner, cpu_wait}, 32'd0);
    @(posedge sysclk); #1;
    reset = 1'b0; halt_b = 1'b1; dma_req = 1'b0; exp_tmo = 1'b0;
    cyc("post_reset", 2'd0);

    // debug request racing a halt request
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h2000; dbg_din = 8'hA5;
    cyc("dbg_no_strobe", 2'd0);
    halt_b = 1'b0; core_latch_data = 1'b1;
    cyc("dbg_vs_dma_1", 2'd3);
    core_latch_data = 1'b0;
    cyc("dbg_vs_dma_2", 2'd3);
    cyc("dbg_vs_dma_own", 2'd1);
    halt_b = 1'b1;
    cyc("dbg_ret_1", 2'd3);
    cyc("dbg_ret_2", 2'd3);
    cyc("dbg_ret_cpu", 2'd0);
    core_latch_data = 1'b1;
    cyc("dbg_grant", c_DBG_OWNER);
    core_latch_data = 1'b0;
    cyc("dbg_single_ack", 2'd0);
    core_latch_data = 1'b1;
    cyc("dbg_separation", 2'd0);
    cyc("dbg_regrant", c_DBG_OWNER);
    dbg_req = 1'b0; core_latch_data = 1'b0;
    cyc("dbg_done", 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
